// File: rtl/error_checking_pkg.sv
// error_checking_pkg: shared constants for the OBC error-checking pipeline
//   QUESTION_WIDTH  width of challenge questions and answers
//   LFSR_TAPS       feedback taps for x^4+x^3+1
//   LFSR_ZERO_SUB   replacement for an all-zero seed (zero is a lock-up state)
//   ST_* / state_t  challenge_issuer state encoding
package error_checking_pkg;
   localparam int QUESTION_WIDTH = 4;
   localparam logic [QUESTION_WIDTH-1:0] LFSR_TAPS = 4'b1100;
   localparam logic [QUESTION_WIDTH-1:0] LFSR_ZERO_SUB = 4'b0001;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ASK = 2'd1;
   localparam logic [1:0] ST_DELIVER = 2'd2;
   localparam logic [1:0] ST_GAP = 2'd3;
   typedef enum logic [1:0] {IDLE = ST_IDLE, ASK = ST_ASK, DELIVER = ST_DELIVER, GAP = ST_GAP} state_t;
   function automatic logic [QUESTION_WIDTH-1:0] fix_seed(input logic [QUESTION_WIDTH-1:0] s);
      return s == '0 ? LFSR_ZERO_SUB : s;
   endfunction
endpackage

// File: rtl/question_lfsr.sv
// question_lfsr: 4-bit Fibonacci LFSR (x^4+x^3+1) producing challenge questions
//   clk    rising-edge clock
//   reset  synchronous active-low reset, loads seed (zero replaced)
//   step   advance one position
//   seed   reset value
//   value  current LFSR state
module question_lfsr import error_checking_pkg::*; (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      step,
   input  logic [QUESTION_WIDTH-1:0] seed,
   output logic [QUESTION_WIDTH-1:0] value
);
   always_ff @(posedge clk)
      if (!reset) value <= fix_seed(seed);
      else if (step) value <= {value[QUESTION_WIDTH-2:0], ^(value & LFSR_TAPS)};
endmodule

// File: rtl/challenge_issuer.sv
// challenge_issuer: poses LFSR questions to the OBC, times out slow answers, hands records to the checker
//   clk, reset                 clock, synchronous active-low reset
//   enable                     permits issuing challenges
//   question, question_valid   challenge posed to the OBC
//   answer_obc, answer_valid   OBC response, sampled only while asking
//   pair_*                     (question, answer, timeout) record, valid/ready handshake
//   timeout_count              saturating count of timeouts since reset
module challenge_issuer import error_checking_pkg::*; #(
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int INTERVAL_CYCLES = 100,
   parameter logic [QUESTION_WIDTH-1:0] LFSR_SEED = 4'b1001
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   output logic [QUESTION_WIDTH-1:0] question,
   output logic                      question_valid,
   input  logic [QUESTION_WIDTH-1:0] answer_obc,
   input  logic                      answer_valid,
   output logic                      pair_valid,
   output logic [QUESTION_WIDTH-1:0] pair_question,
   output logic [QUESTION_WIDTH-1:0] pair_answer,
   output logic                      pair_timeout,
   input  logic                      pair_ready,
   output logic [7:0]                timeout_count
);
   localparam int CMAX = TIMEOUT_CYCLES > INTERVAL_CYCLES ? TIMEOUT_CYCLES : INTERVAL_CYCLES;
   localparam int CW = $clog2(CMAX + 1);
   localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] I_LAST = CW'(INTERVAL_CYCLES - 1);
   state_t state;
   logic [CW-1:0] cnt;
   logic [QUESTION_WIDTH-1:0] lfsr_q;
   logic step;
   assign step = state == DELIVER && pair_ready;
   question_lfsr u_lfsr (.clk(clk), .reset(reset), .step(step), .seed(LFSR_SEED), .value(lfsr_q));
   // cnt holds the number of completed cycles in the current state; every transition clears it
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
         question <= '0;
         question_valid <= 1'b0;
         pair_valid <= 1'b0;
         pair_question <= '0;
         pair_answer <= '0;
         pair_timeout <= 1'b0;
         timeout_count <= '0;
      end else begin
         cnt <= cnt + CW'(1);
         case (state)
            IDLE: if (enable) begin
               state <= ASK;
               cnt <= '0;
               question <= lfsr_q;
               question_valid <= 1'b1;
            end
            // an answer on the final allowed cycle beats the timeout
            ASK: if (answer_valid || cnt == T_LAST) begin
               state <= DELIVER;
               cnt <= '0;
               question_valid <= 1'b0;
               pair_valid <= 1'b1;
               pair_question <= question;
               pair_answer <= answer_valid ? answer_obc : '0;
               pair_timeout <= !answer_valid;
               if (!answer_valid && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
            end
            DELIVER: if (pair_ready) begin
               state <= enable ? GAP : IDLE;
               cnt <= '0;
               pair_valid <= 1'b0;
            end
            GAP: if (!enable) begin
               state <= IDLE;
               cnt <= '0;
            end else if (cnt == I_LAST) begin
               state <= ASK;
               cnt <= '0;
               question <= lfsr_q;
               question_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_challenge_issuer.sv
// tb_challenge_issuer: directed stimulus with a phase-level reference model checked every cycle
module tb_challenge_issuer;
   localparam int TO = 8;
   localparam int IV = 4;
   localparam int SEED = 9;
   logic clk, reset, enable, question_valid, answer_valid, pair_valid, pair_timeout, pair_ready;
   logic [3:0] question, answer_obc, pair_question, pair_answer;
   logic [7:0] timeout_count;
   int n_cmp = 0;
   int n_bad = 0;
   challenge_issuer #(.TIMEOUT_CYCLES(TO), .INTERVAL_CYCLES(IV), .LFSR_SEED(4'b1001)) dut (
      .clk(clk), .reset(reset), .enable(enable), .question(question), .question_valid(question_valid),
      .answer_obc(answer_obc), .answer_valid(answer_valid), .pair_valid(pair_valid),
      .pair_question(pair_question), .pair_answer(pair_answer), .pair_timeout(pair_timeout),
      .pair_ready(pair_ready), .timeout_count(timeout_count)
   );
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end
   task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask
   // k-th question of the sequence, stepping the polynomial arithmetically from the seed
   function automatic logic [3:0] lfsr_at(input int k);
      int v = SEED;
      for (int i = 0; i < k % 15; i++) v = ((v * 2) % 16) + (((v / 8) + (v / 4)) % 2);
      return 4'(v);
   endfunction
   // model: phase 0 idle, 1 ask, 2 deliver, 3 gap; m_n = cycles completed in phase; m_k = records accepted
   int m_ph, m_n, m_k, m_tc;
   logic m_rst;
   logic [3:0] m_q, m_pq, m_pa;
   logic m_pt;
   always @(posedge clk) begin
      m_rst <= !reset;
      if (!reset) begin
         m_ph <= 0; m_n <= 0; m_k <= 0; m_tc <= 0;
         m_q <= 0; m_pq <= 0; m_pa <= 0; m_pt <= 0;
      end else begin
         m_n <= m_n + 1;
         if (m_ph == 0 && enable) begin
            m_ph <= 1; m_n <= 0; m_q <= lfsr_at(m_k);
         end else if (m_ph == 1 && (answer_valid || m_n + 1 == TO)) begin
            m_ph <= 2; m_n <= 0; m_pq <= m_q;
            m_pa <= answer_valid ? answer_obc : 4'd0;
            m_pt <= !answer_valid;
            if (!answer_valid) m_tc <= m_tc + 1 > 255 ? 255 : m_tc + 1;
         end else if (m_ph == 2 && pair_ready) begin
            m_ph <= enable ? 3 : 0; m_n <= 0; m_k <= m_k + 1;
         end else if (m_ph == 3 && !enable) begin
            m_ph <= 0; m_n <= 0;
         end else if (m_ph == 3 && m_n + 1 == IV) begin
            m_ph <= 1; m_n <= 0; m_q <= lfsr_at(m_k);
         end
      end
   end
   always @(negedge clk) begin
      cmp("m_question_valid", 8'(question_valid), 8'(m_ph == 1));
      cmp("m_pair_valid", 8'(pair_valid), 8'(m_ph == 2));
      cmp("m_timeout_count", timeout_count, 8'(m_tc));
      if (m_ph == 1 || m_rst) cmp("m_question", 8'(question), 8'(m_q));
      if (m_ph == 2 || m_rst) begin
         cmp("m_pair_question", 8'(pair_question), 8'(m_pq));
         cmp("m_pair_answer", 8'(pair_answer), 8'(m_pa));
         cmp("m_pair_timeout", 8'(pair_timeout), 8'(m_pt));
      end
   end
   initial begin
      reset = 0; enable = 0; answer_valid = 0; answer_obc = 0; pair_ready = 0;
      tick(2);
      cmp("rst_qv", 8'(question_valid), 8'd0);
      cmp("rst_q", 8'(question), 8'd0);
      cmp("rst_pv", 8'(pair_valid), 8'd0);
      cmp("rst_tc", timeout_count, 8'd0);
      reset = 1; enable = 1;
      tick(1);
      cmp("first_qv", 8'(question_valid), 8'd1);
      cmp("first_q", 8'(question), 8'h9);
      tick(2);
      answer_valid = 1; answer_obc = 4'h5; pair_ready = 1;
      tick(1);
      answer_valid = 0;
      cmp("ans_pv", 8'(pair_valid), 8'd1);
      cmp("ans_pq", 8'(pair_question), 8'h9);
      cmp("ans_pa", 8'(pair_answer), 8'h5);
      cmp("ans_pt", 8'(pair_timeout), 8'd0);
      tick(4);
      cmp("gap_qv", 8'(question_valid), 8'd0);
      tick(1);
      cmp("second_qv", 8'(question_valid), 8'd1);
      cmp("second_q", 8'(question), 8'h3);
      answer_valid = 1; answer_obc = 4'hA;
      tick(1);
      answer_valid = 0;
      tick(5);
      cmp("third_q", 8'(question), 8'h6);
      for (int i = 1; i <= TO; i++) begin
         cmp("to_qv_held", 8'(question_valid), 8'd1);
         tick(1);
      end
      cmp("to_qv_drop", 8'(question_valid), 8'd0);
      cmp("to_pv", 8'(pair_valid), 8'd1);
      cmp("to_pt", 8'(pair_timeout), 8'd1);
      cmp("to_pa", 8'(pair_answer), 8'd0);
      cmp("to_tc", timeout_count, 8'd1);
      tick(5);
      cmp("fourth_q", 8'(question), 8'hD);
      tick(7);
      answer_valid = 1; answer_obc = 4'h7;
      tick(1);
      answer_valid = 0; pair_ready = 0;
      cmp("last_cycle_pt", 8'(pair_timeout), 8'd0);
      cmp("last_cycle_pa", 8'(pair_answer), 8'h7);
      cmp("last_cycle_tc", timeout_count, 8'd1);
      for (int i = 0; i < 20; i++) begin
         answer_valid = (i == 10); answer_obc = 4'hF;
         tick(1);
         cmp("bp_pv", 8'(pair_valid), 8'd1);
         cmp("bp_qv", 8'(question_valid), 8'd0);
         cmp("bp_pa", 8'(pair_answer), 8'h7);
      end
      answer_valid = 0; pair_ready = 1;
      tick(5);
      cmp("fifth_q", 8'(question), 8'hA);
      enable = 0;
      tick(2);
      answer_valid = 1; answer_obc = 4'h3;
      tick(1);
      answer_valid = 0;
      cmp("drop_pv", 8'(pair_valid), 8'd1);
      cmp("drop_pa", 8'(pair_answer), 8'h3);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         cmp("idle_qv", 8'(question_valid), 8'd0);
      end
      enable = 1;
      tick(1);
      cmp("sixth_q", 8'(question), 8'h5);
      answer_valid = 1;
      tick(1);
      answer_valid = 0;
      tick(2);
      enable = 0;
      tick(IV + 2);
      cmp("gap_drop_qv", 8'(question_valid), 8'd0);
      enable = 1;
      tick(1);
      cmp("seventh_q", 8'(question), 8'hB);
      reset = 0;
      tick(1);
      cmp("midrst_qv", 8'(question_valid), 8'd0);
      cmp("midrst_pv", 8'(pair_valid), 8'd0);
      reset = 1;
      tick(1);
      cmp("post_rst_q", 8'(question), 8'h9);
      tick(260 * (TO + 1 + IV) + 20);
      cmp("sat_tc", timeout_count, 8'd255);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
